sr_latch_bank_ctrl: RTL and testbench
=====================================

// Module: sr_latch_bank_ctrl
// PURPOSE
// Sequences set/clear operations onto a bank of NAND SR latches (active-low S/R inputs, S=R=0 forbidden).
// Arbitrates round-robin between NUM_REQ requesters and drives timed low pulses on exactly one latch input.
// Enforces a minimum pulse width and a recovery gap, then checks latch Q against the requested value.
// Sits between control logic and the SR latch array; this block is the only driver of that array's inputs.
// PARAMETERS
// NUM_REQ    4  number of requesters (>=2)
// NUM_LATCH  8  latches in bank (>=2); IDX_W = $clog2(NUM_LATCH)
// PULSE_CYC  2  cycles S_n/R_n held low (>=1)
// GAP_CYC    1  cycles all inputs high after a pulse before next grant (>=1)
// PORTS
// clk      in   1                clock, all logic on rising edge
// rst      in   1                synchronous, active-high reset
// req      in   NUM_REQ          request per requester; held high until ack
// req_op   in   NUM_REQ          per requester: 1=set (Q->1), 0=clear (Q->0)
// req_idx  in   NUM_REQ*IDX_W    per requester latch index, requester i at [i*IDX_W +: IDX_W]
// ack      out  NUM_REQ          one-hot, 1-cycle pulse: request accepted
// S_n      out  NUM_LATCH        active-low set to latch bank
// R_n      out  NUM_LATCH        active-low reset to latch bank
// latch_q  in   NUM_LATCH        Q outputs fed back from bank
// busy     out  1                high in PULSE and GAP
// done     out  1                1-cycle pulse at end of GAP
// err      out  1                valid with done: Q mismatch or bad index
// BEHAVIOUR
// - Reset: S_n=R_n=all 1, ack=0, busy=0, done=0, err=0, state=IDLE, RR pointer=0. Latch contents untouched.
// - FSM IDLE -> PULSE -> GAP -> IDLE. One operation in flight; no pipelining.
// - IDLE: if |req, pick first requester at/after RR pointer; ack[i]=1 that cycle (registered, visible next edge
//   with state=PULSE); capture op/idx; pointer <= i+1 mod NUM_REQ. Grant-to-first-low-pulse latency 1 cycle.
// - PULSE: for PULSE_CYC cycles drive S_n[idx]=0 (set) or R_n[idx]=0 (clear); all other bits 1.
//   S_n[k] and R_n[k] never both 0, never any two latches driven at once (invariant, assert in bench).
// - End of PULSE: sample latch_q[idx] on last pulse cycle; mismatch vs op -> err_pending.
// - GAP: all S_n/R_n=1 for GAP_CYC cycles; on last GAP cycle done=1, err=err_pending; next state IDLE.
//   Earliest next ack: cycle after done (no grant in same cycle as done).
// - idx >= NUM_LATCH: ack still issued, no pulse driven (PULSE stage drives all 1), err=1 with done.
// - Conflicting set/clear to same latch from different requesters: served in RR order, never merged;
//   final Q equals last served op.
// - req dropped before ack: ignored. req held after ack: treated as a new request.
// - Requester's op/idx sampled only in its ack cycle; later changes have no effect.
// - rst mid-PULSE: next edge forces all outputs to reset values; pulse truncated; no done issued.
// - Counter width $clog2(max(PULSE_CYC,GAP_CYC)+1); counter reloads on each state entry.
// STRUCTURE
// - Shared header sr_ctrl_defs.vh: state localparams (ST_IDLE=0, ST_PULSE=1, ST_GAP=2), OP_SET=1, OP_CLR=0.
// - Sub-module rr_arbiter (NUM_REQ param): req, pointer in -> one-hot grant, valid; combinational, reused.
// - Top: FSM, cycle counter, op/idx capture registers, output decode of S_n/R_n, Q check.
// TESTING (bench instantiates real SR latch bank on S_n/R_n/latch_q)
// - Reset then idle 5 cycles -> S_n=R_n=8'hFF, busy=0, ack=0, done=0.
// - req[0], op=1, idx=3 -> ack=4'b0001; S_n=8'hF7 for 2 cycles; 1 gap; done=1, err=0; latch_q[3]=1.
// - req=4'b1111 held, pointer 0 -> acks in order 0,1,2,3,0; each op 4 cycles (1 ack+2 pulse+1 gap).
// - req[1] set idx 5, req[2] clear idx 5 same cycle -> latch_q[5]=1 then 0; never S_n[5]=R_n[5]=0.
// - req[3] idx=9 with NUM_LATCH=8 -> ack, no low on S_n/R_n, done with err=1.
// - rst asserted in 2nd PULSE cycle -> next edge S_n=R_n=all 1, busy=0, no done; pointer back to 0.

Source files
------------

// File: rtl/sr_latch_bank_ctrl_pkg.sv
// Shared types and constants for the SR latch bank controller.
// Holds the FSM encoding, op codes and the counter sizing helper.
package sr_latch_bank_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   function automatic int cnt_w(input int p, input int g);
      int m;
      m = (p > g) ? p : g;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_rr_arbiter.sv
// Round-robin arbiter: first active request at or after the pointer.
// Purely combinational; the caller owns and advances the pointer.
module sr_latch_bank_ctrl_rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
   output logic                       valid_o
);

   localparam int PTR_W = $clog2(NUM_REQ);

   always_comb begin
      int   j;
      logic found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      j         = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         j = int'(ptr_i) + off;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_i[j]) begin
            found     = 1'b1;
            gnt_o[j]  = 1'b1;
            gnt_idx_o = PTR_W'(j);
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Sequences timed active-low set/clear pulses onto a NAND SR latch bank,
// one latch at a time, with round-robin grant and a Q read-back check.
module sr_latch_bank_ctrl
   import sr_latch_bank_ctrl_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_LATCH = 8,
   parameter int IDX_W     = $clog2(NUM_LATCH),
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       req_op,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   output logic [NUM_REQ-1:0]       ack,
   output logic [NUM_LATCH-1:0]     S_n,
   output logic [NUM_LATCH-1:0]     R_n,
   input  logic [NUM_LATCH-1:0]     latch_q,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_w(PULSE_CYC, GAP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   op_q, op_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic                   errp_q, errp_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_LATCH-1:0]   s_n_q, s_n_d;
   logic [NUM_LATCH-1:0]   r_n_q, r_n_d;

   logic [NUM_REQ-1:0]     gnt;
   logic [PTR_W-1:0]       gnt_idx;
   logic                   gnt_valid;
   logic                   sel_op;
   logic [IDX_W-1:0]       sel_idx;
   logic                   q_sel;
   logic                   idx_ok;

   sr_latch_bank_ctrl_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .valid_o   (gnt_valid)
   );

   // Low on the addressed bit only; out-of-range index drives nothing.
   function automatic logic [NUM_LATCH-1:0] drive_lo(
      input logic [IDX_W-1:0] idx,
      input logic             en
   );
      logic [NUM_LATCH-1:0] v;
      v = '1;
      for (int k = 0; k < NUM_LATCH; k++) begin
         if (en && int'(idx) == k) v[k] = 1'b0;
      end
      return v;
   endfunction

   always_comb begin
      sel_op  = req_op[gnt_idx];
      sel_idx = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];
   end

   always_comb begin
      q_sel  = 1'b0;
      idx_ok = 1'b0;
      for (int k = 0; k < NUM_LATCH; k++) begin
         if (int'(idx_q) == k) begin
            q_sel  = latch_q[k];
            idx_ok = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      idx_d   = idx_q;
      errp_d  = errp_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      s_n_d   = '1;
      r_n_d   = '1;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
               op_d    = sel_op;
               idx_d   = sel_idx;
               errp_d  = 1'b0;
               ack_d   = gnt;
               ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ?
                         '0 : gnt_idx + 1'b1;
               s_n_d   = drive_lo(sel_idx, sel_op == OP_SET);
               r_n_d   = drive_lo(sel_idx, sel_op == OP_CLR);
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LD;
               errp_d  = !idx_ok || (q_sel != op_q);
            end else begin
               cnt_d = cnt_q - 1'b1;
               s_n_d = drive_lo(idx_q, op_q == OP_SET);
               r_n_d = drive_lo(idx_q, op_q == OP_CLR);
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         idx_q   <= '0;
         errp_q  <= 1'b0;
         ptr_q   <= '0;
         ack_q   <= '0;
         s_n_q   <= '1;
         r_n_q   <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         errp_q  <= errp_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         s_n_q   <= s_n_d;
         r_n_q   <= r_n_d;
      end
   end

   assign ack  = ack_q;
   assign S_n  = s_n_q;
   assign R_n  = r_n_q;
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_GAP) && (cnt_q == '0);
   assign err  = done && errp_q;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl with a behavioural NAND SR latch bank
// on S_n/R_n/latch_q, a stuck-at-0 hook, and a round-robin model.
module tb_sr_latch_bank_ctrl;

   localparam int NR = 4;
   localparam int NL = 8;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NR-1:0]   req = '0;
   logic [NR-1:0]   req_op = '0;
   logic [NR*IW-1:0] req_idx = '0;
   logic [NR-1:0]   ack;
   logic [NL-1:0]   S_n, R_n;
   logic [NL-1:0]   lq = '0;
   logic [NL-1:0]   stuck = '0;
   logic            busy, done, err;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   sr_latch_bank_ctrl #(
      .NUM_REQ   (NR),
      .NUM_LATCH (NL),
      .IDX_W     (IW),
      .PULSE_CYC (2),
      .GAP_CYC   (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_op  (req_op),
      .req_idx (req_idx),
      .ack     (ack),
      .S_n     (S_n),
      .R_n     (R_n),
      .latch_q (lq),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   // Behavioural NAND latch bank; a stuck bit models a dead cell.
   always @(S_n or R_n or stuck) begin
      for (int k = 0; k < NL; k++) begin
         if (stuck[k])      lq[k] = 1'b0;
         else if (!S_n[k])  lq[k] = 1'b1;
         else if (!R_n[k])  lq[k] = 1'b0;
      end
   end

   // Drive invariant: at most one low line in the whole bank.
   always @(negedge clk) begin
      if (!rst) begin
         n_run++;
         if (($countones(~S_n) + $countones(~R_n)) > 1 ||
             (|(~S_n & ~R_n)) || ($countones(ack) > 1)) begin
            n_fail++;
            $display("FAIL drive_inv: S_n=%h R_n=%h ack=%b", S_n, R_n, ack);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("ack_seen", 32'(ok), 32'd1);
   endtask

   typedef struct {
      int            rq;
      bit            op;
      logic [IW-1:0] idx;
      bit            stk;
      logic [NR-1:0] eack;
      logic [NL-1:0] es;
      logic [NL-1:0] er;
      bit            eerr;
      bit            eq;
   } vec_t;

   vec_t tbl[8];
   int   ptr_m;

   // One randomised transaction against the model's rules.
   task automatic txn(input logic [NR-1:0] mask, input logic [NR-1:0] ops,
                      input logic [NR*IW-1:0] idxs);
      int            g;
      bit            eop;
      int            eidx;
      bit            eq;
      bit            eerr;
      logic [NL-1:0] es, er;
      g = -1;
      for (int o = 0; o < NR; o++) begin
         int j;
         j = (ptr_m + o) % NR;
         if (g < 0 && mask[j]) g = j;
      end
      eop  = ops[g];
      eidx = int'(idxs[g*IW +: IW]);
      es   = (eidx < NL && eop)  ? ~(NL'(1) << eidx) : '1;
      er   = (eidx < NL && !eop) ? ~(NL'(1) << eidx) : '1;
      eq   = (eidx < NL) ? (stuck[eidx] ? 1'b0 : eop) : 1'b0;
      eerr = (eidx >= NL) || (eq != eop);
      ptr_m = (g + 1) % NR;
      req = mask;
      req_op = ops;
      req_idx = idxs;
      tick();
      chk("rnd_ack", 32'(ack), 32'(NR'(1) << g));
      chk("rnd_s1", 32'(S_n), 32'(es));
      chk("rnd_r1", 32'(R_n), 32'(er));
      req = 4'($urandom);
      req_op = 4'($urandom);
      req_idx = 16'($urandom);
      tick();
      chk("rnd_s2", 32'(S_n), 32'(es));
      chk("rnd_r2", 32'(R_n), 32'(er));
      chk("rnd_busy", 32'(busy), 32'd1);
      req = '0;
      tick();
      chk("rnd_done", 32'(done), 32'd1);
      chk("rnd_err", 32'(err), 32'(eerr));
      chk("rnd_gap", 32'({S_n, R_n}), 32'hFFFF);
      if (eidx < NL) chk("rnd_q", 32'(lq[eidx]), 32'(eq));
      tick();
      chk("rnd_idle", 32'({ack, busy, done}), 32'd0);
   endtask

   initial begin
      bit ok;
      int last;

      tbl[0] = '{0, 1'b1, 4'd3, 1'b0, 4'b0001, 8'hF7, 8'hFF, 1'b0, 1'b1};
      tbl[1] = '{2, 1'b0, 4'd3, 1'b0, 4'b0100, 8'hFF, 8'hF7, 1'b0, 1'b0};
      tbl[2] = '{1, 1'b1, 4'd0, 1'b0, 4'b0010, 8'hFE, 8'hFF, 1'b0, 1'b1};
      tbl[3] = '{3, 1'b1, 4'd7, 1'b0, 4'b1000, 8'h7F, 8'hFF, 1'b0, 1'b1};
      tbl[4] = '{3, 1'b1, 4'd9, 1'b0, 4'b1000, 8'hFF, 8'hFF, 1'b1, 1'b0};
      tbl[5] = '{0, 1'b0, 4'd7, 1'b0, 4'b0001, 8'hFF, 8'h7F, 1'b0, 1'b0};
      tbl[6] = '{1, 1'b1, 4'd6, 1'b1, 4'b0010, 8'hBF, 8'hFF, 1'b1, 1'b0};
      tbl[7] = '{2, 1'b0, 4'd6, 1'b1, 4'b0100, 8'hFF, 8'hBF, 1'b0, 1'b0};

      do_reset();
      chk("rst_lines", 32'({S_n, R_n}), 32'hFFFF);
      chk("rst_flags", 32'({ack, busy, done, err}), 32'd0);
      repeat (5) tick();
      chk("idle_lines", 32'({S_n, R_n}), 32'hFFFF);
      chk("idle_flags", 32'({ack, busy, done, err}), 32'd0);

      foreach (tbl[t]) begin
         stuck = tbl[t].stk ? 8'(1 << tbl[t].idx) : 8'h00;
         req = NR'(1) << tbl[t].rq;
         req_op[tbl[t].rq] = tbl[t].op;
         req_idx[tbl[t].rq*IW +: IW] = tbl[t].idx;
         tick();
         chk("tbl_ack", 32'(ack), 32'(tbl[t].eack));
         chk("tbl_s", 32'(S_n), 32'(tbl[t].es));
         chk("tbl_r", 32'(R_n), 32'(tbl[t].er));
         req = '0;
         tick();
         chk("tbl_hold", 32'({ack, S_n, R_n}), 32'({4'b0, tbl[t].es, tbl[t].er}));
         tick();
         chk("tbl_done", 32'({done, err}), 32'({1'b1, tbl[t].eerr}));
         chk("tbl_gap", 32'({S_n, R_n}), 32'hFFFF);
         if (int'(tbl[t].idx) < NL)
            chk("tbl_q", 32'(lq[tbl[t].idx]), 32'(tbl[t].eq));
         tick();
         chk("tbl_end", 32'({done, busy}), 32'd0);
      end
      stuck = '0;

      do_reset();
      req_op = 4'b1111;
      req_idx = {4'd3, 4'd2, 4'd1, 4'd0};
      req = 4'b1111;
      last = 0;
      for (int n = 0; n < 5; n++) begin
         wait_ack(ok);
         chk("rr_ack", 32'(ack), 32'(NR'(1) << (n % NR)));
         if (n > 0) chk("rr_period", 32'(cyc - last), 32'd4);
         last = cyc;
      end
      req = '0;
      repeat (4) tick();

      do_reset();
      req_op = 4'b0010;
      req_idx = {4'd0, 4'd5, 4'd5, 4'd0};
      req = 4'b0110;
      tick();
      chk("cf_ack1", 32'(ack), 32'h2);
      chk("cf_s1", 32'({S_n, R_n}), 32'hDFFF);
      req = 4'b0100;
      tick();
      tick();
      chk("cf_done1", 32'({done, err}), 32'h2);
      chk("cf_q1", 32'(lq[5]), 32'd1);
      tick();
      chk("cf_nogrant", 32'({ack, busy}), 32'd0);
      tick();
      chk("cf_ack2", 32'(ack), 32'h4);
      chk("cf_r2", 32'({S_n, R_n}), 32'hFFDF);
      req = '0;
      tick();
      tick();
      chk("cf_done2", 32'({done, err}), 32'h2);
      chk("cf_q2", 32'(lq[5]), 32'd0);
      tick();

      req_op = 4'b0100;
      req_idx = {4'd0, 4'd4, 4'd0, 4'd0};
      req = 4'b0100;
      tick();
      chk("rp_ack", 32'(ack), 32'h4);
      chk("rp_s1", 32'(S_n), 32'hEF);
      req = 4'b1111;
      tick();
      chk("rp_s2", 32'(S_n), 32'hEF);
      rst = 1'b1;
      tick();
      chk("rp_lines", 32'({S_n, R_n}), 32'hFFFF);
      chk("rp_flags", 32'({ack, busy, done, err}), 32'd0);
      rst = 1'b0;
      tick();
      chk("rp_ptr", 32'(ack), 32'h1);
      req = '0;
      repeat (4) tick();

      do_reset();
      ptr_m = 0;
      for (int n = 0; n < 40; n++) begin
         logic [NR*IW-1:0] idxs;
         for (int r = 0; r < NR; r++)
            idxs[r*IW +: IW] = IW'($urandom_range(0, 11));
         stuck = ($urandom_range(0, 4) == 0) ?
                 8'(1 << $urandom_range(0, 7)) : 8'h00;
         txn(4'($urandom_range(1, 15)), 4'($urandom), idxs);
      end
      stuck = '0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
